// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: FSM phase type, hex glyph
// table and pin-polarity helpers.
package seven_seg_scanner_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } phase_e;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_off(input int com_anode);
    return (com_anode != 0) ? 7'h7F : 7'h00;
  endfunction

  function automatic logic com_on(input int com_anode);
    return (com_anode != 0);
  endfunction

endpackage

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// Nibble to active-high seven-segment glyph; polarity is applied by the caller.
module hex_to_seg
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit seven-segment driver with dead-time blanking,
// leading-zero suppression and frame-synchronous double-buffered loading.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int COM_ANODE    = 1,
  parameter int CLK_HZ       = 12000000,
  parameter int DIGIT_HZ     = 2000,
  parameter int BLANK_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic                    lz_suppress_i,
  input  logic                    load_i,
  output logic [6:0]              seg_o,
  output logic                    dp_out_o,
  output logic [NUM_DIGITS-1:0]   com_o,
  output logic                    frame_start_o
);

  localparam int DIGIT_TICKS = CLK_HZ / DIGIT_HZ;
  localparam int DIV_W       = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
  localparam int IDX_W       = $clog2(NUM_DIGITS);

  localparam logic [6:0] SEG_OFF = seg_off(COM_ANODE);
  localparam logic       COM_ACT = com_on(COM_ANODE);
  localparam logic       DP_OFF  = (COM_ANODE != 0);
  localparam logic [NUM_DIGITS-1:0] COM_IDLE = {NUM_DIGITS{~COM_ACT}};

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seven_seg_scanner: NUM_DIGITS must be 2..8");
  end
  if (BLANK_CYCLES <= 0 || BLANK_CYCLES >= DIGIT_TICKS) begin : g_bad_blank
    $error("seven_seg_scanner: need 0 < BLANK_CYCLES < DIGIT_TICKS");
  end

  typedef logic [NUM_DIGITS-1:0][3:0] nibs_t;

  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  phase_e           state_q, state_d;
  logic             boundary;

  nibs_t                 cap_val_q, cap_val_d, sh_val_q, sh_val_d;
  logic [NUM_DIGITS-1:0] cap_dp_q, cap_dp_d, cap_en_q, cap_en_d;
  logic                  cap_lz_q, cap_lz_d, pend_q, pend_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, sh_en_q, sh_en_d, sh_lzm_q, sh_lzm_d;
  logic [NUM_DIGITS-1:0] lit;
  logic [6:0]            glyph;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_out_q, dp_out_d, fs_q, fs_d;
  logic [NUM_DIGITS-1:0] com_q, com_d;

  // Blank from the top down while digits read as zero; digit 0 always shows.
  function automatic logic [NUM_DIGITS-1:0] lz_scan(input nibs_t v,
                                                     input logic [NUM_DIGITS-1:0] en,
                                                     input logic lz);
    logic [NUM_DIGITS-1:0] m;
    logic blank;
    m     = '0;
    blank = lz;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      blank = blank && (!en[i] || (v[i] == 4'h0));
      m[i]  = blank;
    end
    return m;
  endfunction

  // Prescaler and digit index
  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_W'(DIGIT_TICKS - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  assign boundary = (div_q == '0) && (idx_q == '0);

  // Capture / pending / shadow
  always_comb begin
    cap_val_d = cap_val_q;
    cap_dp_d  = cap_dp_q;
    cap_en_d  = cap_en_q;
    cap_lz_d  = cap_lz_q;
    pend_d    = pend_q;
    sh_val_d  = sh_val_q;
    sh_dp_d   = sh_dp_q;
    sh_en_d   = sh_en_q;
    sh_lzm_d  = sh_lzm_q;
    if (boundary && pend_q) begin
      sh_val_d = cap_val_q;
      sh_dp_d  = cap_dp_q;
      sh_en_d  = cap_en_q;
      sh_lzm_d = lz_scan(cap_val_q, cap_en_q, cap_lz_q);
      pend_d   = 1'b0;
    end
    if (load_i) begin
      cap_val_d = value_i;
      cap_dp_d  = dp_i;
      cap_en_d  = digit_en_i;
      cap_lz_d  = lz_suppress_i;
      pend_d    = 1'b1;
    end
  end

  assign lit = sh_en_q & ~sh_lzm_q;

  hex_to_seg u_dec (
    .nib_i (sh_val_q[idx_q]),
    .seg_o (glyph)
  );

  // Slot FSM: next phase plus next registered pin values
  always_comb begin
    state_d  = state_q;
    seg_d    = SEG_OFF;
    dp_out_d = DP_OFF;
    com_d    = COM_IDLE;
    fs_d     = boundary;
    if (div_d == '0)                         state_d = ST_BLANK;
    else if (div_d == DIV_W'(BLANK_CYCLES))  state_d = ST_ON;
    if (state_q == ST_ON && lit[idx_q]) begin
      com_d[idx_q] = COM_ACT;
      seg_d        = (COM_ANODE != 0) ? ~glyph : glyph;
      dp_out_d     = sh_dp_q[idx_q] ? ~DP_OFF : DP_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      idx_q     <= '0;
      state_q   <= ST_BLANK;
      cap_val_q <= '0;
      cap_dp_q  <= '0;
      cap_en_q  <= '0;
      cap_lz_q  <= 1'b0;
      pend_q    <= 1'b0;
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      sh_en_q   <= '0;
      sh_lzm_q  <= '0;
      seg_q     <= SEG_OFF;
      dp_out_q  <= DP_OFF;
      com_q     <= COM_IDLE;
      fs_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
      cap_val_q <= cap_val_d;
      cap_dp_q  <= cap_dp_d;
      cap_en_q  <= cap_en_d;
      cap_lz_q  <= cap_lz_d;
      pend_q    <= pend_d;
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      sh_en_q   <= sh_en_d;
      sh_lzm_q  <= sh_lzm_d;
      seg_q     <= seg_d;
      dp_out_q  <= dp_out_d;
      com_q     <= com_d;
      fs_q      <= fs_d;
    end
  end

  assign seg_o         = seg_q;
  assign dp_out_o      = dp_out_q;
  assign com_o         = com_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: a frame-arithmetic reference model queues the expected pins
// for every cycle; a negedge monitor pops and compares.
module tb_seven_seg_scanner;

  localparam int N     = 4;
  localparam int TICKS = 10;
  localparam int BLANK = 2;
  localparam int FRAME = N * TICKS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0, en = '0;
  logic        lz = 1'b0, load = 1'b0;
  logic [6:0]  seg;
  logic        dp_out, fs;
  logic [3:0]  com;

  seven_seg_scanner #(
    .NUM_DIGITS(N), .COM_ANODE(1), .CLK_HZ(1000), .DIGIT_HZ(100), .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value_i(value), .dp_i(dp), .digit_en_i(en),
    .lz_suppress_i(lz), .load_i(load), .seg_o(seg), .dp_out_o(dp_out),
    .com_o(com), .frame_start_o(fs)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dpo;
    logic [3:0] com;
    logic       fs;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0, errors = 0;

  logic [6:0] hex_tbl [16];
  initial begin
    hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  end

  // Reference model state
  int          c = 0;
  int          m_slot, m_ph;
  logic        pend = 1'b0, m_lit;
  logic [15:0] cap_v = '0, sh_v = '0;
  logic [3:0]  cap_dp = '0, cap_en = '0, sh_dp = '0, sh_en = '0, sh_mask = '0;
  logic        cap_lz = 1'b0;
  obs_t        m_e;

  // Digits above the highest enabled nonzero digit go dark (digit 0 never does).
  function automatic logic [3:0] lz_ref(input logic [15:0] v, input logic [3:0] e, input logic l);
    int top;
    logic [3:0] m;
    top = 0;
    m   = '0;
    if (!l) return m;
    for (int i = 0; i < N; i++)
      if (e[i] && ((v >> (4 * i)) & 16'hF) != 0) top = i;
    for (int i = 0; i < N; i++) m[i] = (i > top);
    return m;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_e = '{seg: 7'h7F, dpo: 1'b1, com: 4'b0000, fs: 1'b0};
      exp_q.push_back(m_e);
      c = 0; pend = 1'b0; sh_en = '0; sh_mask = '0; sh_v = '0; sh_dp = '0;
    end else begin
      m_slot = (c % FRAME) / TICKS;
      m_ph   = c % TICKS;
      m_lit  = sh_en[m_slot] && !sh_mask[m_slot];
      m_e    = '{seg: 7'h7F, dpo: 1'b1, com: 4'b0000, fs: (c % FRAME == 0)};
      if (m_ph >= BLANK && m_lit) begin
        m_e.com[m_slot] = 1'b1;
        m_e.seg = ~hex_tbl[(sh_v >> (4 * m_slot)) & 16'hF];
        m_e.dpo = ~sh_dp[m_slot];
      end
      exp_q.push_back(m_e);
      if (c % FRAME == 0 && pend) begin
        sh_v = cap_v; sh_dp = cap_dp; sh_en = cap_en;
        sh_mask = lz_ref(cap_v, cap_en, cap_lz);
        pend = 1'b0;
      end
      if (load) begin
        cap_v = value; cap_dp = dp; cap_en = en; cap_lz = load ? lz : cap_lz;
        pend = 1'b1;
      end
      c++;
    end
  end

  // Monitor
  obs_t got, want;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = '{seg: seg, dpo: dp_out, com: com, fs: fs};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pins t=%0t got seg=%h dp=%b com=%b fs=%b want seg=%h dp=%b com=%b fs=%b",
                 $time, got.seg, got.dpo, got.com, got.fs, want.seg, want.dpo, want.com, want.fs);
      end
    end
  end

  task automatic check_idle(input string name);
    checks++;
    if (seg !== 7'h7F || com !== 4'b0000 || dp_out !== 1'b1 || fs !== 1'b0) begin
      errors++;
      $display("FAIL %s got seg=%h com=%b dp=%b fs=%b want seg=7f com=0000 dp=1 fs=0",
               name, seg, com, dp_out, fs);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e, input logic l);
    value = v; dp = d; en = e; lz = l; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int g;
    g = 0;
    while ((c % FRAME) != ph && g < 2 * FRAME) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2 * FRAME) begin
      checks++; errors++;
      $display("FAIL wait_phase got timeout want phase %0d", ph);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_idle("reset_async_start");
    cyc(3);
    rst_n = 1'b1;
    cyc(200);

    do_load(16'h1A80, 4'h0, 4'hF, 1'b0);
    cyc(100);
    do_load(16'h0005, 4'h0, 4'hF, 1'b1);
    cyc(100);
    do_load(16'h0000, 4'h0, 4'hF, 1'b1);
    cyc(100);

    wait_phase(17);
    do_load(16'h1234, 4'h0, 4'hF, 1'b0);
    wait_phase(0);
    do_load(16'h5678, 4'h0, 4'hF, 1'b0);
    cyc(120);

    do_load(16'h9C3B, 4'b0100, 4'b1011, 1'b0);
    cyc(100);

    for (int k = 0; k < 30; k++) begin
      cyc($urandom_range(0, 60));
      do_load(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    end
    cyc(100);

    do_load(16'h4321, 4'hF, 4'hF, 1'b0);
    cyc(90);
    wait_phase(10);
    do_load(16'h8888, 4'h0, 4'hF, 1'b0);
    wait_phase(25);
    #1 rst_n = 1'b0;
    #1 check_idle("reset_async_mid");
    cyc(3);
    rst_n = 1'b1;
    cyc(120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
